// File: rtl/axi_burst_reader.sv
// AXI4 read master: issues one INCR burst per request and streams the returned beats
// out through a 2-entry skid FIFO, pulsing rmst_done once every beat has been delivered.
module axi_burst_reader #(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned BURST_LENGTH = 4,
    parameter int unsigned ID_WIDTH     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rmst_req,
    input  logic [ADDR_WIDTH-1:0] addr_offset,
    output logic                  rmst_done,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  valid,
    input  logic                  ready
);

    localparam int unsigned SizeLog = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CntW    = 9;
    localparam logic [ADDR_WIDTH-1:0] LowMask = ADDR_WIDTH'((1 << SizeLog) - 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    state_e                state_q;
    logic [CntW-1:0]       beat_cnt_q;
    logic [DATA_WIDTH-1:0] fifo_mem_q [2];
    logic                  fifo_rd_ptr_q;
    logic                  fifo_wr_ptr_q;
    logic [1:0]            fifo_cnt_q;
    logic [1:0]            fifo_cnt_next;
    logic                  push;
    logic                  pop;
    logic                  last_beat;
    logic                  drain_done;

    assign m_axi_arlen   = 8'(BURST_LENGTH - 1);
    assign m_axi_arsize  = 3'(SizeLog);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = '0;

    assign push       = (state_q == StData) && m_axi_rvalid && m_axi_rready;
    assign valid      = (fifo_cnt_q != 2'd0);
    assign pop        = valid && ready;
    assign tdata      = fifo_mem_q[fifo_rd_ptr_q];
    assign last_beat  = (beat_cnt_q == LastIdx);
    // Finishing on the cycle the final beat leaves saves a cycle per burst.
    assign drain_done = (state_q == StDrain) &&
                        ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop));
    assign rmst_done  = drain_done;
    assign busy       = (state_q != StIdle);

    always_comb begin
        fifo_cnt_next = fifo_cnt_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            beat_cnt_q    <= '0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem_q[i] <= '0;
            end
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            err           <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem_q[fifo_wr_ptr_q] <= m_axi_rdata;
                fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
            end
            if (pop) begin
                fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_next;

            unique case (state_q)
                StIdle: begin
                    if (rmst_req) begin
                        m_axi_araddr  <= addr_offset & ~LowMask;
                        m_axi_arvalid <= 1'b1;
                        state_q       <= StAddr;
                    end
                end
                StAddr: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        beat_cnt_q    <= '0;
                        m_axi_rready  <= (fifo_cnt_next < 2'd2);
                        state_q       <= StData;
                    end
                end
                StData: begin
                    // rready is registered, so it reflects the FIFO room after this edge.
                    m_axi_rready <= (fifo_cnt_next < 2'd2) && !(push && last_beat);
                    if (push) begin
                        beat_cnt_q <= beat_cnt_q + CntW'(1);
                        if (m_axi_rresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        if (last_beat) begin
                            if (!m_axi_rlast) begin
                                err <= 1'b1;
                            end
                            state_q <= StDrain;
                        end else if (m_axi_rlast) begin
                            err <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    m_axi_rready <= 1'b0;
                    if (drain_done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader: a queue-based model of the delivered stream plus
// literal expectations for addresses, beat counts and error flags.
module tb_axi_burst_reader;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int BL = 4;
    localparam int IW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rmst_req;
    logic [AW-1:0] addr_offset;
    logic          rmst_done;
    logic          busy;
    logic          err;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic [IW-1:0] m_axi_arid;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] tdata;
    logic          valid;
    logic          ready;

    always #5 clk = ~clk;

    axi_burst_reader #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BURST_LENGTH(BL),
        .ID_WIDTH    (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rmst_req     (rmst_req),
        .addr_offset  (addr_offset),
        .rmst_done    (rmst_done),
        .busy         (busy),
        .err          (err),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arid   (m_axi_arid),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .tdata        (tdata),
        .valid        (valid),
        .ready        (ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model of what the stream must carry, as seen from the AXI and output handshakes.
    logic [DW-1:0] exp_q[$];
    int            r_acc;
    bit            m_busy;
    bit            m_err;
    logic [AW-1:0] exp_addr;
    bit            chk_en;

    // Handshakes that will complete at the coming edge.
    bit            f_ar, f_r, f_out, f_done;
    logic [DW-1:0] f_rdata;
    logic [1:0]    f_rresp;
    logic          f_rlast;

    // Slave and downstream configuration.
    int            ar_wait, ar_delay, s_idx, burst_no, rdy_mode, cyc;
    bit            s_active;
    logic [1:0]    s_resp [BL];
    logic          s_last [BL];

    // Per-burst statistics for the literal checks.
    int            st_ar, st_out, st_done, st_valid;
    logic [AW-1:0] st_addr;
    logic [7:0]    st_arlen;
    logic [2:0]    st_arsize;
    logic [1:0]    st_arburst;
    logic [IW-1:0] st_arid;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int b, input int i);
        return {16{32'(b * 256 + i)}};
    endfunction

    task automatic cycle();
        bit req_s, rst_s, exp_done;
        logic [AW-1:0] addr_s;
        @(negedge clk);
        cyc++;
        req_s  = rmst_req;
        rst_s  = rst;
        addr_s = addr_offset;
        if (rst_s) begin
            exp_q.delete();
            r_acc    = 0;
            m_busy   = 0;
            m_err    = 0;
            s_active = 0;
            s_idx    = 0;
        end else begin
            if (req_s && !m_busy) begin
                m_busy   = 1;
                exp_addr = addr_s & ~64'h3f;
            end
            if (f_ar) begin
                st_ar++;
                s_active = 1;
                s_idx    = 0;
            end
            if (f_r) begin
                exp_q.push_back(f_rdata);
                r_acc++;
                if (f_rresp != 2'b00) m_err = 1;
                if (f_rlast != (r_acc == BL)) m_err = 1;
                s_idx++;
                if (s_idx >= BL) s_active = 0;
            end
            if (f_out && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                st_out++;
            end
            if (f_done) begin
                st_done++;
                m_busy = 0;
                r_acc  = 0;
            end
        end
        // Slave and downstream drive.
        if (m_axi_arvalid === 1'b1) ar_wait++;
        else ar_wait = 0;
        m_axi_arready = (m_axi_arvalid === 1'b1) && (ar_wait > ar_delay);
        m_axi_rvalid  = s_active;
        m_axi_rdata   = beat(burst_no, s_idx);
        m_axi_rresp   = (s_idx < BL) ? s_resp[s_idx] : 2'b00;
        m_axi_rlast   = (s_idx < BL) ? s_last[s_idx] : 1'b0;
        ready         = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        #1;
        f_ar    = m_axi_arvalid && m_axi_arready;
        f_r     = m_axi_rvalid && m_axi_rready;
        f_out   = valid && ready;
        f_done  = rmst_done;
        f_rdata = m_axi_rdata;
        f_rresp = m_axi_rresp;
        f_rlast = m_axi_rlast;
        if (f_ar) begin
            st_addr    = m_axi_araddr;
            st_arlen   = m_axi_arlen;
            st_arsize  = m_axi_arsize;
            st_arburst = m_axi_arburst;
            st_arid    = m_axi_arid;
        end
        if (valid) st_valid++;
        if (chk_en) begin
            exp_done = m_busy && (r_acc == BL) &&
                       ((exp_q.size() == 0) || (exp_q.size() == 1 && f_out));
            chk("valid", valid, exp_q.size() != 0);
            if (f_out && exp_q.size() != 0) chk("tdata", tdata, exp_q[0]);
            chk("rmst_done", rmst_done, exp_done);
            chk("busy", busy, m_busy);
            chk("err", err, m_err);
            if (m_axi_arvalid) chk("araddr", m_axi_araddr, exp_addr);
            if (exp_q.size() == 2) chk("rready_when_full", m_axi_rready, 1'b0);
        end
    endtask

    task automatic clear_stats();
        st_ar = 0; st_out = 0; st_done = 0; st_valid = 0;
    endtask

    task automatic cfg(input int bn, input int bad_beat, input logic [BL-1:0] last_mask);
        burst_no = bn;
        for (int i = 0; i < BL; i++) begin
            s_resp[i] = (i == bad_beat) ? 2'b10 : 2'b00;
            s_last[i] = last_mask[i];
        end
    endtask

    task automatic start(input logic [AW-1:0] a);
        addr_offset = a;
        rmst_req    = 1'b1;
        cycle();
        rmst_req    = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (st_done == 0 && t < 300) begin
            cycle();
            t++;
        end
        if (st_done == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no rmst_done expected one within 300 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rmst_req = 1'b0; addr_offset = '0; ready = 1'b1;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        chk_en = 0; ar_wait = 0; ar_delay = 2; s_idx = 0; s_active = 0;
        rdy_mode = 0; cyc = 0; r_acc = 0; m_busy = 0; m_err = 0; exp_addr = '0;
        f_ar = 0; f_r = 0; f_out = 0; f_done = 0;
        cfg(1, -1, 4'b1000);
        clear_stats();
        cycle();
        cycle();
        chk_en = 1;
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_tdata", tdata, '0);
        rst = 1'b0;
        cycle();

        // Basic burst.
        clear_stats();
        start(64'h1000);
        wait_done();
        chk("basic_araddr", st_addr, 64'h1000);
        chk("basic_arlen", st_arlen, 8'd3);
        chk("basic_arsize", st_arsize, 3'd6);
        chk("basic_arburst", st_arburst, 2'b01);
        chk("basic_arid", st_arid, '0);
        chk("basic_out_beats", st_out, 4);
        chk("basic_valid_cycles", st_valid, 4);
        chk("basic_done_count", st_done, 1);
        chk("basic_err", err, 1'b0);

        // Backpressure.
        cycle();
        cfg(2, -1, 4'b1000);
        rdy_mode = 1;
        clear_stats();
        start(64'h2000);
        wait_done();
        chk("bp_out_beats", st_out, 4);
        chk("bp_done_count", st_done, 1);
        rdy_mode = 0;

        // Unaligned address.
        cycle();
        cfg(3, -1, 4'b1000);
        clear_stats();
        start(64'h1023);
        wait_done();
        chk("unaligned_araddr", st_addr, 64'h1000);

        // Bad RRESP on beat 1; err must survive a following clean burst.
        cycle();
        cfg(4, 1, 4'b1000);
        clear_stats();
        start(64'h1100);
        wait_done();
        chk("rresp_err", err, 1'b1);
        chk("rresp_done", st_done, 1);
        cycle();
        cfg(5, -1, 4'b1000);
        clear_stats();
        start(64'h1200);
        wait_done();
        chk("err_sticky", err, 1'b1);

        // Early RLAST on beat 2.
        do_reset();
        cfg(6, -1, 4'b1100);
        clear_stats();
        start(64'h1300);
        wait_done();
        chk("early_rlast_err", err, 1'b1);

        // Missing RLAST on beat 3.
        do_reset();
        cfg(7, -1, 4'b0000);
        clear_stats();
        start(64'h1400);
        wait_done();
        chk("missing_rlast_err", err, 1'b1);
        chk("missing_rlast_beats", st_out, 4);

        // Request while busy, then back-to-back request right after rmst_done.
        do_reset();
        cfg(8, -1, 4'b1000);
        clear_stats();
        start(64'h3000);
        for (int t = 0; t < 50 && !s_active; t++) cycle();
        start(64'h9000);
        wait_done();
        chk("busy_req_ar_count", st_ar, 1);
        chk("busy_req_araddr", st_addr, 64'h3000);
        cfg(9, -1, 4'b1000);
        clear_stats();
        start(64'h4000);
        wait_done();
        chk("next_req_ar_count", st_ar, 1);
        chk("next_req_araddr", st_addr, 64'h4000);
        chk("next_req_done", st_done, 1);

        // Reset in the middle of DATA.
        cycle();
        cfg(10, -1, 4'b1000);
        clear_stats();
        start(64'h5000);
        for (int t = 0; t < 50 && r_acc < 2; t++) cycle();
        chk("mid_beats_before_rst", r_acc, 2);
        do_reset();
        chk("mid_rst_arvalid", m_axi_arvalid, 1'b0);
        chk("mid_rst_rready", m_axi_rready, 1'b0);
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        cycle();
        cfg(11, -1, 4'b1000);
        clear_stats();
        start(64'h6000);
        wait_done();
        chk("post_rst_beats", st_out, 4);
        chk("post_rst_done", st_done, 1);
        chk("post_rst_err", err, 1'b0);
        chk("post_rst_araddr", st_addr, 64'h6000);

        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_burst_reader.md
Name: axi_burst_reader

Overview:
- AXI4 read master that sits directly upstream of the switch buffer.
- Takes one read-request pulse plus a byte address, issues a single INCR burst of BURST_LENGTH beats on AR, and streams the returned R beats out on a valid/ready interface through a 2-entry skid FIFO.
- Pulses rmst_done once every beat of the burst has been handed downstream. The switch buffer then advances its address and may issue the next request.
- One burst is outstanding at a time.

Parameters:
- DATA_WIDTH, 512, width of the AXI R data bus and of the output stream; must be a power of two and at least 8.
- ADDR_WIDTH, 64, AXI address width.
- BURST_LENGTH, 4, beats per burst; legal range 1..256.
- ID_WIDTH, 1, AXI ID width; ARID is driven to 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rmst_req  in  1  start-burst pulse; sampled only in IDLE
- addr_offset  in  ADDR_WIDTH  burst byte address, sampled with rmst_req
- rmst_done  out  1  one-cycle pulse when the burst is fully delivered downstream
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky flag for a non-OKAY RRESP or an RLAST mismatch; cleared only by rst
- m_axi_araddr  out  ADDR_WIDTH  burst address
- m_axi_arlen  out  8  BURST_LENGTH-1
- m_axi_arsize  out  3  log2(DATA_WIDTH/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arid  out  ID_WIDTH  constant 0
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- tdata  out  DATA_WIDTH  output beat; driven from the skid FIFO head
- valid  out  1  output valid; high when the skid FIFO is not empty
- ready  in  1  downstream ready

Behaviour:
- Reset (rst high at a clk edge):
  - Outputs go to: state=IDLE, arvalid=0, rready=0, valid=0, rmst_done=0, busy=0, err=0.
  - Beat counter and skid FIFO are cleared; tdata goes to 0.
  - Reset mid-burst abandons the transaction; recovering the AXI slave is the system's responsibility.
- State machine: IDLE, ADDR, DATA, DRAIN.
  - IDLE: if rmst_req=1, register araddr = addr_offset with its low log2(DATA_WIDTH/8) bits forced to 0, then go to ADDR. arvalid is 1 on the next cycle.
  - ADDR: hold arvalid=1 with araddr stable until arready=1. On that handshake edge set arvalid=0, clear the beat counter, go to DATA.
  - DATA: m_axi_rready = skid FIFO not full (registered). Each edge with rvalid&&rready pushes rdata into the FIFO and increments the counter.
    - On the beat where counter==BURST_LENGTH-1: if rlast!=1, set err. Go to DRAIN.
    - On any earlier beat: if rlast=1, set err. Stay in DATA and keep counting until BURST_LENGTH beats have been accepted.
    - For every accepted beat, rresp!=2'b00 sets err.
  - DRAIN: rready=0. When the FIFO is empty, or will be empty after this cycle's pop, drive rmst_done=1 for exactly one cycle and go to IDLE.
- rmst_req arriving in ADDR, DATA or DRAIN is ignored and not queued. rmst_req in the same cycle that rmst_done is high is also ignored, because the state is DRAIN that cycle.
- Earliest next request: the cycle after rmst_done. The switch buffer's request timing satisfies this.
- Skid FIFO:
  - 2 entries; pop when valid&&ready.
  - Push and pop in the same cycle while full is legal and keeps the count at 2.
  - FIFO order is preserved.
  - Output path has zero added latency: a beat pushed at edge N is visible on tdata/valid after edge N.
- Throughput: with ready and rvalid held high, one beat per cycle.
- busy = (state != IDLE).

Test Plan:
- Basic burst: rmst_req with addr_offset=0x1000, arready after 2 cycles; slave returns 4 beats back-to-back with rlast on beat 3; ready=1 -> araddr=0x1000, arlen=3, arsize=6; valid high for exactly 4 consecutive cycles with the data in order; one rmst_done pulse; err=0.
- Backpressure: ready toggles 1,0,0,1,... while the slave holds rvalid=1 -> rready drops when the FIFO is full; no beat lost or duplicated; rmst_done only after the 4th output handshake.
- Unaligned address: addr_offset=0x1023 -> araddr=0x1000.
- Error cases:
  - rresp=2'b10 on beat 1 -> err=1 and stays 1; the burst still completes with rmst_done.
  - rlast early on beat 2 -> err=1.
  - rlast missing on beat 3 -> err=1, burst ends after 4 beats.
- Request while busy: second rmst_req during DATA -> exactly one AR handshake; a request issued 1 cycle after rmst_done starts a new burst.
- Reset mid-DATA after 2 beats -> next cycle arvalid=0, rready=0, valid=0, busy=0; a fresh request then performs a full correct 4-beat burst.
